// File: rtl/board_controller.sv
// Four-column drop-game controller: accepts a column, stacks a piece in the lowest free row,
// waits for the external winner detector to settle, then passes the turn or ends the game.
module board_controller #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_col,
    output logic        move_ready,
    input  logic [1:0]  game_status,
    output logic [15:0] game_board,
    output logic [15:0] player_cells,
    output logic        current_player,
    output logic        move_done,
    output logic        move_rejected,
    output logic [4:0]  move_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PLACE, SETTLE, CHECK, OVER} state_t;

    state_t        state, state_nxt;
    logic [1:0]    col;
    logic [CW-1:0] settle_cnt;
    logic [3:0]    col_bits;
    logic          col_full;
    logic [1:0]    row;
    logic          do_write, do_reject, do_toggle, load_settle;

    // col_bits[r] is the occupancy of row r in the latched column
    always_comb begin
        col_bits = {game_board[{2'd3, col}], game_board[{2'd2, col}],
                    game_board[{2'd1, col}], game_board[{2'd0, col}]};
        col_full = &col_bits;
        if (!col_bits[0])      row = 2'd0;
        else if (!col_bits[1]) row = 2'd1;
        else if (!col_bits[2]) row = 2'd2;
        else                   row = 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        do_write    = 1'b0;
        do_reject   = 1'b0;
        do_toggle   = 1'b0;
        load_settle = 1'b0;
        case (state)
            IDLE:   if (move_valid) state_nxt = PLACE;
            PLACE: begin
                if (col_full) begin
                    do_reject = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    do_write    = 1'b1;
                    load_settle = 1'b1;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: if (settle_cnt == '0) state_nxt = CHECK;
            CHECK: begin
                if (game_status != 2'b00) begin
                    state_nxt = OVER;
                end else begin
                    do_toggle = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
        // a clear request overrides whatever the FSM was about to do, including a write
        if (new_game) begin
            state_nxt   = IDLE;
            do_write    = 1'b0;
            do_reject   = 1'b0;
            do_toggle   = 1'b0;
            load_settle = 1'b0;
        end
    end

    assign move_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= 2'd0;
            settle_cnt <= '0;
        end else begin
            if (state == IDLE && move_valid && !new_game) col <= move_col;
            if (load_settle)
                settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_board     <= 16'h0000;
            player_cells   <= 16'h0000;
            current_player <= 1'b0;
            move_count     <= 5'd0;
            move_done      <= 1'b0;
            move_rejected  <= 1'b0;
        end else if (new_game) begin
            game_board     <= 16'h0000;
            player_cells   <= 16'h0000;
            current_player <= 1'b0;
            move_count     <= 5'd0;
            move_done      <= 1'b0;
            move_rejected  <= 1'b0;
        end else begin
            move_done     <= do_write;
            move_rejected <= do_reject;
            if (do_write) begin
                game_board[{row, col}]   <= 1'b1;
                player_cells[{row, col}] <= current_player;
                if (move_count != 5'd16) move_count <= move_count + 5'd1;
            end
            if (do_toggle) current_player <= ~current_player;
        end
    end

endmodule

// File: tb/tb_board_controller.sv
// Self-checking bench for board_controller: directed scenarios plus a random game,
// compared against a column-height/owner-grid model of the board.
module tb_board_controller;

    localparam int S = 3;

    logic        clk = 1'b0;
    logic        reset, new_game, move_valid;
    logic [1:0]  move_col, game_status;
    logic        move_ready, current_player, move_done, move_rejected;
    logic [15:0] game_board, player_cells;
    logic [4:0]  move_count;

    board_controller #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_col(move_col), .move_ready(move_ready), .game_status(game_status),
        .game_board(game_board), .player_cells(player_cells),
        .current_player(current_player), .move_done(move_done),
        .move_rejected(move_rejected), .move_count(move_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: stack height per column and owner of every stacked piece
    int height[4];
    bit owner[4][4];
    int m_count;
    bit m_player;
    bit m_over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_board();
        logic [15:0] b = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (r < height[c]) b[r*4+c] = 1'b1;
        return b;
    endfunction

    function automatic logic [15:0] m_cells();
        logic [15:0] b = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (r < height[c] && owner[r][c]) b[r*4+c] = 1'b1;
        return b;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < 4; c++) height[c] = 0;
        m_count  = 0;
        m_player = 1'b0;
        m_over   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_board"},  game_board,     m_board());
        chk({tag, "_cells"},  player_cells,   m_cells());
        chk({tag, "_count"},  move_count,     m_count);
        chk({tag, "_player"}, current_player, m_player);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_board"},  game_board,     16'h0000);
        chk({tag, "_cells"},  player_cells,   16'h0000);
        chk({tag, "_player"}, current_player, 1'b0);
        chk({tag, "_count"},  move_count,     5'd0);
        chk({tag, "_done"},   move_done,      1'b0);
        chk({tag, "_rej"},    move_rejected,  1'b0);
    endtask

    // all tasks start and end just after a falling edge
    task automatic clear_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_clear();
        check_all("clear");
        chk("clear_ready", move_ready, 1'b1);
    endtask

    task automatic move(input logic [1:0] c, input logic [1:0] st);
        chk("ready_idle", move_ready, 1'b1);
        move_valid  = 1'b1;
        move_col    = c;
        game_status = st;
        @(negedge clk);
        move_valid = 1'b0;
        move_col   = ~c;
        chk("place_ready", move_ready, 1'b0);
        chk("place_done", move_done, 1'b0);
        @(negedge clk);
        if (height[c] == 4) begin
            chk("rej_pulse", move_rejected, 1'b1);
            chk("rej_done", move_done, 1'b0);
            chk("rej_ready", move_ready, 1'b1);
            check_all("rej");
            @(negedge clk);
            chk("rej_one_cycle", move_rejected, 1'b0);
            return;
        end
        owner[height[c]][c] = m_player;
        height[c]++;
        m_count++;
        chk("done_pulse", move_done, 1'b1);
        chk("done_rej", move_rejected, 1'b0);
        chk("write_ready", move_ready, 1'b0);
        check_all("write");
        for (int i = 1; i <= S + 1; i++) begin
            @(negedge clk);
            if (i == 1) chk("done_one_cycle", move_done, 1'b0);
            if (i <= S) begin
                chk("settle_ready", move_ready, 1'b0);
            end else begin
                if (st != 2'b00) m_over = 1'b1;
                else m_player = ~m_player;
                chk("post_check_ready", move_ready, st == 2'b00);
                check_all("post_check");
            end
        end
    endtask

    task automatic poke_over(input int n);
        for (int i = 0; i < n; i++) begin
            move_valid = 1'b1;
            move_col   = 2'($urandom_range(3));
            @(negedge clk);
            chk("over_ready", move_ready, 1'b0);
            chk("over_done", move_done, 1'b0);
            check_all("over");
        end
        move_valid = 1'b0;
    endtask

    // begin a move, let it run k edges past acceptance, then reset
    task automatic reset_mid(input logic [1:0] c, input int k);
        move_valid = 1'b1;
        move_col   = c;
        @(negedge clk);
        move_valid = 1'b0;
        for (int i = 1; i < k; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        m_clear();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_ready", move_ready, 1'b1);
        @(negedge clk);
        check_reset_vals("after_mid_reset");
        chk("after_mid_reset_ready", move_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0;
        move_col = 2'd0; game_status = 2'b00;
        m_clear();
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", move_ready, 1'b1);

        // single move in column 2
        move(2'd2, 2'b00);
        chk("m1_board", game_board, 16'h0004);
        chk("m1_cells", player_cells, 16'h0000);
        chk("m1_player", current_player, 1'b1);
        chk("m1_count", move_count, 5'd1);

        // three stacked moves in column 1, alternating players
        clear_game();
        repeat (3) move(2'd1, 2'b00);
        chk("stack_board", game_board, 16'h0222);
        chk("stack_cells", player_cells, 16'h0020);
        chk("stack_player", current_player, 1'b1);

        // fill column 0, then a rejected fifth drop
        clear_game();
        repeat (5) move(2'd0, 2'b00);
        chk("full_count", move_count, 5'd4);
        chk("full_board", game_board, 16'h1111);
        chk("full_player", current_player, 1'b0);

        // winner reported in CHECK ends the game until new_game
        clear_game();
        move(2'd3, 2'b01);
        game_status = 2'b00;
        chk("win_ready", move_ready, 1'b0);
        poke_over(5);
        clear_game();
        chk("win_clear_board", game_board, 16'h0000);

        // reset during PLACE and during SETTLE of the third move
        clear_game();
        move(2'd1, 2'b00);
        move(2'd2, 2'b00);
        reset_mid(2'd3, 1);
        move(2'd1, 2'b00);
        move(2'd2, 2'b00);
        reset_mid(2'd3, 3);

        // new_game with a simultaneous move: the move is dropped
        move(2'd2, 2'b00);
        new_game = 1'b1; move_valid = 1'b1; move_col = 2'd1;
        @(negedge clk);
        new_game = 1'b0; move_valid = 1'b0;
        m_clear();
        chk("ng_ready", move_ready, 1'b1);
        check_all("ng");
        @(negedge clk);
        chk("ng_done", move_done, 1'b0);
        check_all("ng_after");

        // random play with occasional game endings
        for (int k = 0; k < 80; k++) begin
            logic [1:0] c;
            logic [1:0] st;
            c  = 2'($urandom_range(3));
            st = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            move(c, st);
            game_status = 2'b00;
            if (m_over) begin
                poke_over(2);
                clear_game();
            end else if (m_count == 16 && $urandom_range(1) == 1) begin
                clear_game();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_controller.md
BOARD_CONTROLLER -- requirements
Module: board_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: number of cycles between a board update and the first cycle in which game_status reflects it (winner-detector latency).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 new_game  input  1  synchronous clear request, sampled every cycle.
REQ-005 move_valid  input  1  a drop request is presented.
REQ-006 move_col  input  2  column (0-3) to drop into; valid with move_valid.
REQ-007 move_ready  output  1  controller can accept a move this cycle.
REQ-008 game_status  input  2  from the winner detector: 00 playing, 01 P1 wins, 10 P2 wins, 11 tie.
REQ-009 game_board  output  16  occupancy; bit r*4+c set when row r, column c is filled.
REQ-010 player_cells  output  16  owner per occupied cell: 0 = P1, 1 = P2; 0 where unoccupied.
REQ-011 current_player  output  1  player to move: 0 = P1, 1 = P2.
REQ-012 move_done  output  1  one-cycle pulse when a piece has been written.
REQ-013 move_rejected  output  1  one-cycle pulse when the requested column was full.
REQ-014 move_count  output  5  pieces placed since the last clear, 0-16.

Function
REQ-015 The controller SHALL have states IDLE, PLACE, SETTLE, CHECK and OVER.
REQ-016 move_ready SHALL be 1 only in IDLE.
REQ-017 A move SHALL be accepted on an edge where the state is IDLE, move_valid=1 and new_game=0: latch move_col, go to PLACE.
REQ-018 move_valid outside IDLE SHALL be ignored, with no buffering.
REQ-019 Row 0 (bits 3:0) SHALL be the bottom row; column c consists of cells c, c+4, c+8, c+12.
REQ-020 In PLACE, if the column has an empty cell, the lowest empty row r SHALL be written at the exiting edge: game_board[r*4+c]<=1, player_cells[r*4+c]<=current_player, move_count increments, move_done=1 for the following cycle, next state SETTLE.
REQ-021 In PLACE, if column c is full (all four bits set), the board SHALL be left unchanged, move_rejected=1 for the following cycle, next state IDLE, current_player unchanged.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles (internal counter), then go to CHECK.
REQ-023 In CHECK, if game_status != 00, the next state SHALL be OVER with current_player unchanged; otherwise current_player SHALL toggle and the next state SHALL be IDLE.
REQ-024 OVER SHALL hold the board and the outputs until new_game or reset; move_valid SHALL be ignored in OVER.
REQ-025 new_game=1 on any edge SHALL clear game_board, player_cells and move_count, set current_player=0, force the state to IDLE, and suppress move_done/move_rejected; new_game SHALL take priority over a simultaneous move_valid.
REQ-026 Accepted move to write: 2 edges; accept to the next move_ready: SETTLE_CYCLES+3 cycles.
REQ-027 move_count SHALL saturate at 16; a 17th write is impossible because every column is full at that point.

Reset
REQ-028 While reset=1: state=IDLE, game_board=0, player_cells=0, current_player=0, move_count=0, move_done=0, move_rejected=0, move_ready=1 after release.
REQ-029 Reset asserted mid-move (PLACE/SETTLE/CHECK) SHALL discard the move completely, with no partial write.

Verification
REQ-030 After reset, move col 2 -> game_board=0x0004, player_cells=0x0000, move_done pulse, current_player=1 after CHECK, move_count=1.
REQ-031 Alternate moves col 1, col 1, col 1 -> game_board=0x0222, player_cells=0x0020, current_player=1.
REQ-032 Fill col 0 four times, then a fifth move col 0 -> move_rejected pulse, board unchanged, current_player unchanged, move_count=4.
REQ-033 Drive game_status=01 during CHECK -> state OVER, move_ready=0, further move_valid has no effect; new_game -> board=0, current_player=0, move_ready=1.
REQ-034 Assert reset during SETTLE of the 3rd move -> all outputs return to reset values and no write occurs; new_game and move_valid together in IDLE -> board clears and the move is dropped.
